decoder_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder; next generation of the team's 3-to-8 combinational decoder.
- Adds a valid/ready input handshake, a registered output with valid, range checking, and three modes:
  - DIRECT: decode each accepted input.
  - ACCUM: OR each accepted input into a sticky mask.
  - SCAN: self-timed walking one-hot sequencer.
- Used as a chip-select / row-select generator and as a scan strobe source.

---
 rtl/decoder_seq_pkg.sv | 29 ++
 rtl/decoder_seq_onehot_dec.sv | 22 ++
 rtl/decoder_seq.sv | 137 +++++++++++++
 tb/tb_decoder_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_seq_pkg.sv
// decoder_seq_pkg: mode encodings, FSM state type and per-bit decode helpers
// shared by decoder_seq and onehot_dec.
package decoder_seq_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_SCAN   = 2'd1;
  localparam logic [1:0] MODE_ACCUM  = 2'd2;
  localparam logic [1:0] MODE_THERMO = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DIRECT = 3'd1;
  localparam state_t ST_ACCUM  = 3'd2;
  localparam state_t ST_SCAN   = 3'd3;
  localparam state_t ST_THERMO = 3'd4;

  // Bit 'pos' of a w-wide one-hot of idx; out-of-range idx decodes to all zeros.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos,
                                      input int unsigned w);
    return (idx < w) && (idx == pos);
  endfunction

  // Bit 'pos' of a w-wide thermometer (bits [idx:0] set); out-of-range idx saturates.
  function automatic logic thermo_bit(input int unsigned idx, input int unsigned pos,
                                      input int unsigned w);
    return (idx >= w) || (pos <= idx);
  endfunction

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec: combinational IN_W-to-OUT_W decoder (one-hot or thermometer)
// with an out-of-range flag. One instance is shared by every mode.
module onehot_dec
  import decoder_seq_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  sel,
  input  logic             thermo,
  output logic [OUT_W-1:0] vec,
  output logic             rng
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign vec[i] = thermo ? thermo_bit(32'(sel), i, OUT_W)
                           : onehot_bit(32'(sel), i, OUT_W);
  end

  assign rng = 32'(sel) >= 32'(OUT_W);

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-one-hot decoder with valid/ready input,
// DIRECT / ACCUM / SCAN modes and range checking.
// Optional THERMO mode (mode=3) when DECODER_SEQ_THERMO_EN is defined;
// otherwise mode=3 decodes exactly like DIRECT.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  dec_in,
  output logic [OUT_W-1:0] dec_out,
  output logic             out_valid,
  output logic [IN_W-1:0]  scan_idx,
  output logic             wrap,
  output logic             range_err
);

  localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_TC   = PW'(SCAN_DIV - 1);
  localparam logic [IN_W-1:0] IDX_LAST = IN_W'(OUT_W - 1);

  state_t           state, nxt_state;
  logic [PW-1:0]    presc;
  logic [IN_W-1:0]  idx_nxt, dec_sel;
  logic [OUT_W-1:0] dec_vec;
  logic             dec_rng, thermo_sel, chg, accept, scan_tc;

  // Next state: enable low parks in IDLE, otherwise mode picks the state.
  always_comb begin
    nxt_state = ST_IDLE;
    if (enable) begin
      case (mode)
        MODE_SCAN:   nxt_state = ST_SCAN;
        MODE_ACCUM:  nxt_state = ST_ACCUM;
`ifdef DECODER_SEQ_THERMO_EN
        MODE_THERMO: nxt_state = ST_THERMO;
`endif
        default:     nxt_state = ST_DIRECT;
      endcase
    end
  end

  assign chg = (nxt_state != state);

  // Ready drops in the cycle a mode change is pending so no input is
  // consumed by a state that is about to be left.
  assign in_ready = enable && !chg &&
                    (state == ST_DIRECT || state == ST_ACCUM || state == ST_THERMO);
  assign accept   = in_valid && in_ready;
  assign scan_tc  = (presc == PRE_TC);
  assign idx_nxt  = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;

  // Decoder input: dec_in normally; in SCAN the index being stepped to,
  // or 0 on SCAN entry and on clear.
  always_comb begin
    dec_sel = dec_in;
    if (nxt_state == ST_SCAN)
      dec_sel = (state != ST_SCAN || clear) ? '0 : idx_nxt;
  end

`ifdef DECODER_SEQ_THERMO_EN
  assign thermo_sel = (state == ST_THERMO);
`else
  assign thermo_sel = 1'b0;
`endif

  onehot_dec #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dec (
    .sel    (dec_sel),
    .thermo (thermo_sel),
    .vec    (dec_vec),
    .rng    (dec_rng)
  );

  // State, output register, prescaler and scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dec_out   <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      presc     <= '0;
      wrap      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state     <= nxt_state;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      range_err <= 1'b0;
      if (chg) begin
        presc    <= '0;
        scan_idx <= '0;
        dec_out  <= (nxt_state == ST_SCAN) ? dec_vec : '0;
      end else begin
        case (state)
          ST_SCAN: begin
            if (clear) begin
              presc    <= '0;
              scan_idx <= '0;
              dec_out  <= dec_vec;
            end else if (scan_tc) begin
              presc     <= '0;
              scan_idx  <= idx_nxt;
              dec_out   <= dec_vec;
              out_valid <= 1'b1;
              wrap      <= (scan_idx == IDX_LAST);
            end else begin
              presc <= presc + 1'b1;
            end
          end
          ST_ACCUM: begin
            // clear wins; a simultaneous input is still consumed
            if (clear)       dec_out <= '0;
            else if (accept) dec_out <= dec_out | dec_vec;
            out_valid <= accept;
            range_err <= accept && dec_rng;
          end
          ST_IDLE: dec_out <= '0;
          default: begin
            if (accept) dec_out <= dec_vec;
            out_valid <= accept;
            range_err <= accept && dec_rng;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed bench for decoder_seq. Two instances share the
// stimulus: an 8-output build and a 6-output build (non-power-of-two).
module tb_decoder_seq;
  import decoder_seq_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] dec_in = 3'd0;

  logic       rdy8, ov8, wrap8, rerr8;
  logic [7:0] do8;
  logic [2:0] si8;
  logic       rdy6, ov6, wrap6, rerr6;
  logic [5:0] do6;
  logic [2:0] si6;

  decoder_seq #(.IN_W(3), .OUT_W(8), .SCAN_DIV(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy8), .dec_in(dec_in), .dec_out(do8),
    .out_valid(ov8), .scan_idx(si8), .wrap(wrap8), .range_err(rerr8)
  );

  decoder_seq #(.IN_W(3), .OUT_W(6), .SCAN_DIV(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy6), .dec_in(dec_in), .dec_out(do6),
    .out_valid(ov6), .scan_idx(si6), .wrap(wrap6), .range_err(rerr6)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d8;
    logic [5:0] d6;
    logic       r6;
    logic       w6;
  } exp_t;

  exp_t sb[$];

`ifdef DECODER_SEQ_THERMO_EN
  localparam logic [7:0] M3_EXP = 8'h07;
`else
  localparam logic [7:0] M3_EXP = 8'h04;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d8, input logic [5:0] d6, input logic r6,
                      input logic w6);
    exp_t e;
    e.d8 = d8; e.d6 = d6; e.r6 = r6; e.w6 = w6;
    sb.push_back(e);
  endtask

  // Compare one accepted input's result on both instances.
  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ov8"},  32'(ov8),   32'd1);
      chk({tag, "_d8"},   32'(do8),   32'(e.d8));
      chk({tag, "_ov6"},  32'(ov6),   32'd1);
      chk({tag, "_d6"},   32'(do6),   32'(e.d6));
      chk({tag, "_rng6"}, 32'(rerr6), 32'(e.r6));
    end
  endtask

  initial begin
    exp_t e;
    int   gap;

    // reset state
    #1;
    chk("rst_do8", 32'(do8), 0);
    chk("rst_ov8", 32'(ov8), 0);
    chk("rst_si6", 32'(si6), 0);
    chk("rst_rdy8", 32'(rdy8), 0);
    chk("rst_rng6", 32'(rerr6), 0);

    // SCAN on the 6-output instance: 01 then 02..20,01 every 4 cycles
    tick();
    rst_n = 1'b1; enable = 1'b1; mode = MODE_SCAN;
    tick();
    chk("scan_entry_d6", 32'(do6), 32'h01);
    chk("scan_entry_si6", 32'(si6), 0);
    chk("scan_entry_ov6", 32'(ov6), 0);
    push(8'h00, 6'h02, 1'b0, 1'b0);
    push(8'h00, 6'h04, 1'b0, 1'b0);
    push(8'h00, 6'h08, 1'b0, 1'b0);
    push(8'h00, 6'h10, 1'b0, 1'b0);
    push(8'h00, 6'h20, 1'b0, 1'b0);
    push(8'h00, 6'h01, 1'b0, 1'b1);
    gap = 0;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      tick();
      gap++;
      chk("scan_rdy6", 32'(rdy6), 0);
      if (ov6) begin
        e = sb.pop_front();
        chk("scan_d6", 32'(do6), 32'(e.d6));
        chk("scan_wrap6", 32'(wrap6), 32'(e.w6));
        chk("scan_gap", 32'(gap), 32'd4);
        gap = 0;
      end else begin
        chk("scan_nowrap6", 32'(wrap6), 0);
      end
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL scan_timeout observed=%0d_left expected=0_left", sb.size());
      sb.delete();
    end

    // async reset mid-SCAN at index 5
    for (int c = 0; c < 40 && si6 != 3'd5; c++) tick();
    chk("scan_at5", 32'(si6), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_do6", 32'(do6), 0);
    chk("arst_si6", 32'(si6), 0);
    chk("arst_ov6", 32'(ov6), 0);
    chk("arst_do8", 32'(do8), 0);
    mode = MODE_DIRECT;
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_rdy_idle", 32'(rdy8), 0);
    tick();
    chk("post_rst_rdy", 32'(rdy8), 1);

    // DIRECT: decode 3, then hold with out_valid low
    dec_in = 3'd3; in_valid = 1'b1;
    push(8'h08, 6'h08, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    pop_chk("direct3");
    tick();
    chk("direct_hold_d8", 32'(do8), 32'h08);
    chk("direct_hold_ov8", 32'(ov8), 0);

    // range: 7 is out of range for 6 outputs only
    dec_in = 3'd7; in_valid = 1'b1;
    push(8'h80, 6'h00, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    pop_chk("direct7");
    chk("direct7_rng8", 32'(rerr8), 0);
    tick();
    chk("rng_pulse_end", 32'(rerr6), 0);

    // mode change DIRECT->ACCUM with 0x10 showing
    dec_in = 3'd4; in_valid = 1'b1;
    push(8'h10, 6'h10, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    pop_chk("direct4");
    mode = MODE_ACCUM;
    #1;
    chk("chg_rdy_low", 32'(rdy8), 0);
    tick();
    chk("chg_clr_d8", 32'(do8), 0);
    chk("chg_rdy_back", 32'(rdy8), 1);

    // ACCUM: 0,2,7 then clear with a simultaneous accept of 1
    in_valid = 1'b1;
    dec_in = 3'd0; push(8'h01, 6'h01, 1'b0, 1'b0); tick(); pop_chk("acc0");
    dec_in = 3'd2; push(8'h05, 6'h05, 1'b0, 1'b0); tick(); pop_chk("acc2");
    dec_in = 3'd7; push(8'h85, 6'h05, 1'b1, 1'b0); tick(); pop_chk("acc7");
    clear  = 1'b1; dec_in = 3'd1;
    push(8'h00, 6'h00, 1'b0, 1'b0); tick(); pop_chk("acc_clr");
    clear = 1'b0; in_valid = 1'b0;

    // mode 3: thermometer when built in, otherwise plain decode
    mode = MODE_THERMO;
    tick();
    chk("m3_entry_d8", 32'(do8), 0);
    dec_in = 3'd2; in_valid = 1'b1;
    push(M3_EXP, M3_EXP[5:0], 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    pop_chk("mode3");

    // enable low: inputs ignored, outputs idle
    enable = 1'b0; in_valid = 1'b1; dec_in = 3'd5;
    #1;
    chk("dis_rdy", 32'(rdy8), 0);
    tick();
    chk("dis_d8", 32'(do8), 0);
    chk("dis_ov8", 32'(ov8), 0);
    tick();
    chk("dis_d8_hold", 32'(do8), 0);
    chk("dis_si8", 32'(si8), 0);
    chk("dis_wrap8", 32'(wrap8), 0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
